// File: rtl/video_pkg.sv
// Shared video/Wishbone definitions for the mire pattern generator.
// Contents: pixel type, colour constants, master FSM state encoding,
// Wishbone cycle-type/burst-type constants and small helper functions.
package video_pkg;

  localparam int unsigned PIX_W  = 24;
  localparam int unsigned WORD_W = 32;

  typedef logic [PIX_W-1:0] pixel_t;

  localparam pixel_t C_WHITE   = 24'hFF_FF_FF;
  localparam pixel_t C_YELLOW  = 24'hFF_FF_00;
  localparam pixel_t C_CYAN    = 24'h00_FF_FF;
  localparam pixel_t C_GREEN   = 24'h00_FF_00;
  localparam pixel_t C_MAGENTA = 24'hFF_00_FF;
  localparam pixel_t C_RED     = 24'hFF_00_00;
  localparam pixel_t C_BLUE    = 24'h00_00_FF;
  localparam pixel_t C_BLACK   = 24'h00_00_00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2
  } wshb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Colour of vertical bar idx, left to right.
  function automatic pixel_t bar_colour(input logic [2:0] idx);
    pixel_t c;
    c = C_BLACK;
    unique case (idx)
      3'd0: c = C_WHITE;
      3'd1: c = C_YELLOW;
      3'd2: c = C_CYAN;
      3'd3: c = C_GREEN;
      3'd4: c = C_MAGENTA;
      3'd5: c = C_RED;
      3'd6: c = C_BLUE;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

  // Framebuffer word for one pixel: upper byte always zero.
  function automatic logic [WORD_W-1:0] pixel_word(input pixel_t p);
    return {8'h00, p};
  endfunction

endpackage

// File: rtl/mire_pattern.sv
// Registered test-pattern generator.
// Produces the colour of pixel (x,y); the register loads on 'advance' so
// the caller presents the coordinates of the pixel that comes next.
// Optional build macro: MIRE_COLOR_EN (colour bars behind the grid;
// without it, non-grid pixels are black).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   advance     load the pattern for (x,y)
//   x, y        coordinates of the next pixel
//   pixel       registered RGB colour, reset value = colour of (0,0)
module mire_pattern
  import video_pkg::*;
#(
  parameter int unsigned HDISP = 800,
  parameter int unsigned VDISP = 400,
  parameter int unsigned GRID  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     advance,
  input  logic [$clog2(HDISP)-1:0] x,
  input  logic [$clog2(VDISP)-1:0] y,
  output pixel_t                   pixel
);

  localparam int unsigned CW = 32;

  logic   on_grid;
  pixel_t pixel_d;

  // GRID is a power of two, so the modulo reduces to a mask.
  always_comb begin
    on_grid = ((CW'(x) & CW'(GRID - 1)) == '0) ||
              ((CW'(y) & CW'(GRID - 1)) == '0);
`ifdef MIRE_COLOR_EN
    pixel_d = on_grid ? C_WHITE : bar_colour(3'((CW'(x) << 3) / CW'(HDISP)));
`else
    pixel_d = on_grid ? C_WHITE : C_BLACK;
`endif
  end

  // (0,0) lies on the grid in every build, hence white at reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel <= C_WHITE;
    end else if (advance) begin
      pixel <= pixel_d;
    end
  end

endmodule

// File: rtl/wshb_mire.sv
// Wishbone B4 classic write master that continuously paints a test
// pattern (mire) into the SDRAM framebuffer, one 32-bit word per pixel.
// The bus is dropped for one cycle every BURST_LEN beats so the display
// reader can win arbitration.
// Optional build macro: MIRE_COLOR_EN (passed through to mire_pattern).
// Ports:
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   enable               run request; 0 = stop after the current beat
//   wshb_cyc/stb/we      cycle, strobe, write enable (registered)
//   wshb_adr             byte address of the current pixel
//   wshb_dat_ms          write data {8'h00,R,G,B}
//   wshb_sel             byte select, 4'hF while strobing
//   wshb_cti/bte         classic cycle, linear burst (constants)
//   wshb_ack/err/rty     slave response
//   frame_done           pulse after the last pixel of a frame is taken
//   err_cnt              saturating count of error responses
module wshb_mire
  import video_pkg::*;
#(
  parameter int unsigned HDISP     = 800,
  parameter int unsigned VDISP     = 400,
  parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
  parameter int unsigned BURST_LEN = 64,
  parameter int unsigned GRID      = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [31:0] wshb_adr,
  output logic [31:0] wshb_dat_ms,
  output logic [3:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic        wshb_ack,
  input  logic        wshb_err,
  input  logic        wshb_rty,
  output logic        frame_done,
  output logic [15:0] err_cnt
);

  localparam int unsigned XW    = $clog2(HDISP);
  localparam int unsigned YW    = $clog2(VDISP);
  localparam int unsigned BW    = $clog2(BURST_LEN);
  localparam int unsigned ADR_W = 32;
  localparam int unsigned ERR_W = 16;

  wshb_state_e     state, state_next;
  logic [XW-1:0]   x, x_nxt;
  logic [YW-1:0]   y, y_nxt;
  logic [BW-1:0]   bcnt;
  logic [ADR_W-1:0] adr;
  logic [ERR_W-1:0] errs;
  logic            cyc_q, cyc_d;
  logic [3:0]      sel_q, sel_d;
  logic            fd_q, fd_d;
  pixel_t          pixel;

  logic            beat_done;
  logic            beat_err;
  logic            retry;
  logic            last_x, last_y, last_px;
  logic            burst_end;

  // A beat completes on ack or err; err takes precedence for counting,
  // and either one outranks a retry.
  assign beat_done = (state == WRITE) && (wshb_ack || wshb_err);
  assign beat_err  = (state == WRITE) && wshb_err;
  assign retry     = (state == WRITE) && wshb_rty && !wshb_ack && !wshb_err;

  assign last_x    = (x == XW'(HDISP - 1));
  assign last_y    = (y == YW'(VDISP - 1));
  assign last_px   = last_x && last_y;
  assign burst_end = (bcnt == BW'(BURST_LEN - 1));

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (enable) state_next = WRITE;
      end
      WRITE: begin
        if (retry) begin
          state_next = WRITE;
        end else if (beat_done) begin
          if (burst_end)    state_next = RELEASE;
          else if (!enable) state_next = IDLE;
        end
      end
      RELEASE: begin
        state_next = enable ? WRITE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode; looks at the next state so the registered strobes
  // line up with the state they belong to.
  always_comb begin
    cyc_d = 1'b0;
    sel_d = 4'h0;
    fd_d  = 1'b0;
    if (state_next == WRITE) begin
      cyc_d = 1'b1;
      sel_d = 4'hF;
    end
    if (beat_done && last_px) begin
      fd_d = 1'b1;
    end
  end

  // Bus control registers; reset removes cyc/stb without waiting for a clock.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cyc_q <= 1'b0;
      sel_q <= 4'h0;
      fd_q  <= 1'b0;
    end else begin
      cyc_q <= cyc_d;
      sel_q <= sel_d;
      fd_q  <= fd_d;
    end
  end

  // Coordinates of the pixel following the current one.
  always_comb begin
    x_nxt = x + XW'(1);
    y_nxt = y;
    if (last_x) begin
      x_nxt = '0;
      y_nxt = last_y ? '0 : y + YW'(1);
    end
  end

  // Position, address, burst and error bookkeeping; all move only when a
  // beat completes, so a retried beat repeats the same address and data.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x    <= '0;
      y    <= '0;
      adr  <= BASE_ADR;
      bcnt <= '0;
      errs <= '0;
    end else if (beat_done) begin
      x    <= x_nxt;
      y    <= y_nxt;
      adr  <= last_px ? BASE_ADR : adr + ADR_W'(4);
      bcnt <= burst_end ? '0 : bcnt + BW'(1);
      if (beat_err && (errs != '1)) begin
        errs <= errs + ERR_W'(1);
      end
    end
  end

  mire_pattern #(
    .HDISP (HDISP),
    .VDISP (VDISP),
    .GRID  (GRID)
  ) u_pattern (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .advance (beat_done),
    .x       (x_nxt),
    .y       (y_nxt),
    .pixel   (pixel)
  );

  assign wshb_cyc    = cyc_q;
  assign wshb_stb    = cyc_q;
  assign wshb_we     = cyc_q;
  assign wshb_sel    = sel_q;
  assign wshb_adr    = adr;
  assign wshb_dat_ms = pixel_word(pixel);
  assign wshb_cti    = CTI_CLASSIC;
  assign wshb_bte    = BTE_LINEAR;
  assign frame_done  = fd_q;
  assign err_cnt     = errs;

endmodule
